tsv_link_arbiter: RTL



---
 rtl/tsv_link_arbiter_if.sv | 44 ++++
 rtl/tsv_link_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/tsv_link_arbiter_if.sv
// tsv_link_arbiter_if: requester handshake and TSV beat bundle for
// tsv_link_arbiter. The master modport is the requester / receiving-layer
// side; the slave modport is the arbiter itself.
// Optional: TSV_LINK_PARITY_EN adds the tsv_par beat-parity signal.
interface tsv_link_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int LANES = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               tsv_stall;
  logic               tsv_valid;
  logic               tsv_sof;
  logic [IDW-1:0]     tsv_id;
  logic [LANES-1:0]   tsv_data;
  logic               busy;
`ifdef TSV_LINK_PARITY_EN
  logic               tsv_par;

  modport master (
    output req_valid, req_data, tsv_stall,
    input  req_ready, tsv_valid, tsv_sof, tsv_id, tsv_data, busy, tsv_par
  );

  modport slave (
    input  req_valid, req_data, tsv_stall,
    output req_ready, tsv_valid, tsv_sof, tsv_id, tsv_data, busy, tsv_par
  );
`else
  modport master (
    output req_valid, req_data, tsv_stall,
    input  req_ready, tsv_valid, tsv_sof, tsv_id, tsv_data, busy
  );

  modport slave (
    input  req_valid, req_data, tsv_stall,
    output req_ready, tsv_valid, tsv_sof, tsv_id, tsv_data, busy
  );
`endif
endinterface

// File: rtl/tsv_link_arbiter.sv
// tsv_link_arbiter: round-robin arbiter that serialises one DW-bit payload
// per frame over LANES TSV lanes, LSB slice first, tagged with the requester
// ID and a start-of-frame flag.
// Optional: TSV_LINK_PARITY_EN adds tsv_par, the XOR of each beat's lanes.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no frame on the lanes; any valid requester is granted now
// S_SEND | frame in flight; a new grant only on an unstalled last beat
module tsv_link_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int LANES = 4
) (
  input  logic clk1,
  input  logic rst,
  tsv_link_arbiter_if.slave bus
);
  localparam int IDW   = $clog2(NREQ);
  localparam int BEATS = DW / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [BW-1:0]    r_beat;
  logic [DW-1:0]    r_shift;
  logic             r_valid;
  logic             r_sof;
  logic [LANES-1:0] r_data;

  logic [IDW-1:0]   w_winner;
  logic [IDW-1:0]   w_cand;
  logic             w_found;
  logic             w_last;
  logic             w_slot_open;
  logic             w_accept;
  logic [NREQ-1:0]  w_ready;
  logic [DW-1:0]    w_payload;
  logic [DW-1:0]    w_shift_nxt;

  // Round-robin search from r_ptr; descending loop so the closest candidate wins.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_cand   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = r_ptr + IDW'(k);
      if (bus.req_valid[w_cand]) begin
        w_winner = w_cand;
        w_found  = 1'b1;
      end
    end
  end

  assign w_last      = (r_beat == BW'(BEATS - 1));
  assign w_slot_open = (r_state == S_IDLE) || (w_last && !bus.tsv_stall);
  assign w_accept    = w_found && w_slot_open;
  assign w_payload   = bus.req_data[w_winner*DW +: DW];
  assign w_shift_nxt = r_shift >> LANES;

  // Next state and grant; a grant on the last beat chains frames without a bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_ready[w_winner] = 1'b1;
          w_state_nxt       = S_SEND;
        end
      end
      S_SEND: begin
        if (w_last && !bus.tsv_stall) begin
          if (w_found) begin
            w_ready[w_winner] = 1'b1;
            w_state_nxt       = S_SEND;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk1) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Datapath: load on accept, shift one slice per unstalled beat, hold otherwise.
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_ptr   <= '0;
      r_id    <= '0;
      r_beat  <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_data  <= '0;
    end else if (w_accept) begin
      r_shift <= w_payload;
      r_id    <= w_winner;
      r_beat  <= '0;
      r_ptr   <= w_winner + 1'b1;
      r_valid <= 1'b1;
      r_sof   <= 1'b1;
      r_data  <= w_payload[LANES-1:0];
    end else if (r_state == S_SEND && !bus.tsv_stall) begin
      r_sof <= 1'b0;
      if (!w_last) begin
        r_beat  <= r_beat + 1'b1;
        r_shift <= w_shift_nxt;
        r_data  <= w_shift_nxt[LANES-1:0];
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef TSV_LINK_PARITY_EN
  logic r_par;

  // Beat parity tracks r_data load-for-load so it holds exactly when the data holds.
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= ^w_payload[LANES-1:0];
    end else if (r_state == S_SEND && !bus.tsv_stall && !w_last) begin
      r_par <= ^w_shift_nxt[LANES-1:0];
    end
  end

  assign bus.tsv_par = r_par;
`endif

  assign bus.req_ready = w_ready;
  assign bus.tsv_valid = r_valid;
  assign bus.tsv_sof   = r_sof;
  assign bus.tsv_id    = r_id;
  assign bus.tsv_data  = r_data;
  assign bus.busy      = (r_state == S_SEND);
endmodule
